// File: rtl/dmem_write_buffer_if.sv
// Core-side and dmem-side signals of the store write buffer.
// slave: the buffer itself; master: the core plus dmem environment.
interface dmem_write_buffer_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          cpu_we;
    logic          cpu_re;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wd;
    logic [DW-1:0] cpu_rd;
    logic          cpu_stall;
    logic          mem_we;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rd;

    modport slave (
        input  cpu_we, cpu_re, cpu_addr, cpu_wd,
        output cpu_rd, cpu_stall,
        output mem_we, mem_a, mem_wd,
        input  mem_rd
    );

    modport master (
        output cpu_we, cpu_re, cpu_addr, cpu_wd,
        input  cpu_rd, cpu_stall,
        input  mem_we, mem_a, mem_wd,
        output mem_rd
    );
endinterface

// File: rtl/dmem_write_buffer.sv
// Store write buffer between the memory stage and single-port dmem.
// DMEM_WB_FORWARD_EN: forward buffered data to loads instead of stalling.
module dmem_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    dmem_write_buffer_if.slave   bus,
    output logic                 empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0] ent_a [DEPTH];
    logic [DW-1:0] ent_d [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic [PW-1:0] idx;
    logic          hit;
    logic          full;
    logic          load_stall;
    logic          port_load;
    logic          drain;
    logic          push;
`ifdef DMEM_WB_FORWARD_EN
    logic [DW-1:0] hit_d;
`endif

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // Scan valid entries oldest to youngest; the last match wins.
    always_comb begin
        hit = 1'b0;
        idx = head;
`ifdef DMEM_WB_FORWARD_EN
        hit_d = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if ((CW'(i) < count) && (ent_a[idx] == bus.cpu_addr)) begin
                hit = 1'b1;
`ifdef DMEM_WB_FORWARD_EN
                hit_d = ent_d[idx];
`endif
            end
        end
    end

`ifdef DMEM_WB_FORWARD_EN
    assign load_stall = 1'b0;
    assign bus.cpu_rd = hit ? hit_d : bus.mem_rd;
`else
    // A matching load waits and yields the port so the buffer drains.
    assign load_stall = bus.cpu_re & hit;
    assign bus.cpu_rd = bus.mem_rd;
`endif

    assign port_load = bus.cpu_re & ~load_stall;
    assign drain     = ~empty & ~port_load;
    assign push      = bus.cpu_we & (~full | drain);

    assign bus.cpu_stall = (bus.cpu_we & full & ~drain) | load_stall;
    assign bus.mem_we    = drain;
    assign bus.mem_a     = drain ? ent_a[head] : bus.cpu_addr;
    assign bus.mem_wd    = ent_d[head];

    // Entry payload; contents need no reset since count gates validity.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_a[tail] <= bus.cpu_addr;
            ent_d[tail] <= bus.cpu_wd;
        end
    end

    // Pointers and occupancy; reset discards any pending stores.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (drain) head <= head + 1'b1;
            if (push)  tail <= tail + 1'b1;
            unique case ({push, drain})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule
